sobel_edge_param: RTL
=====================

# sobel_edge_param

Parametrised Sobel edge detector for raster-scan greyscale streams. It accepts one pixel per valid cycle and buffers two image lines internally in inferred RAM, so it needs no FIFO IP. It computes |Gx|+|Gy| over each interior 3×3 window and emits either a thresholded binary pixel or a saturated magnitude pixel. It sits between the UART RX byte stream and the TX/frame-store path, and is the successor of the fixed 180×180, 8-bit, compile-time-threshold detector.

## Interface

**Parameters**
- `DATA_W`, 8: pixel width in bits.
- `IMG_W`, 180: pixels per line; must be ≥ 3.
- `IMG_H`, 180: lines per frame; must be ≥ 3.
- `EDGE_VAL`, 0: binary-mode value for an edge pixel (all-zero, black).
- `FLAT_VAL`, 2^DATA_W−1: binary-mode value for a non-edge pixel (all-ones, white).

**Ports**
- `sys_clk`, in, 1: clock.
- `sys_rst`, in, 1: reset; one clock; reset is asynchronous and active-high.
- `data_in`, in, `DATA_W`: input pixel, raster order.
- `in_valid`, in, 1: `data_in` is valid this cycle. No backpressure exists.
- `threshold`, in, `DATA_W+3`: edge threshold, compared unsigned against the magnitude.
- `mode`, in, 1: 0 selects binary output; 1 selects magnitude output.
- `data_out`, out, `DATA_W`: output pixel.
- `out_valid`, out, 1: `data_out` is valid this cycle.
- `frame_done`, out, 1: one-cycle pulse coincident with the last output pixel of a frame.

## Operation

**Counters**
- `col` runs 0..IMG_W−1 and `row` runs 0..IMG_H−1.
- Both advance only on `in_valid`.
- `col` wraps to 0 and increments `row`; `row` wraps to 0 at the end of the frame.

**Line buffers**
- Two RAMs, each `IMG_W` × `DATA_W`, addressed by `col`.
- On `in_valid`, RAM1[col] is written with RAM0[col] (old value) and RAM0[col] is written with `data_in`.
- Net effect: RAM1 holds line r−2 and RAM0 holds line r−1.
- RAM contents are not reset.

**Window**
- A 3×3 register array shifts left by one column on each `in_valid`.
- The new right column is {RAM1[col], RAM0[col], data_in}.
- The window is valid when the sampled pixel has row ≥ 2 and col ≥ 2. Its centre is then pixel (row−1, col−1).

**Arithmetic (widths)**
- Gx = (a3−a1) + 2(b3−b1) + (c3−c1), and Gy = (a1−c1) + 2(a2−c2) + (a3−c3), where a, b, c are the top, middle and bottom window rows and 1, 2, 3 are the left, centre and right columns.
- Gx and Gy are signed, `DATA_W+3` bits.
- mag = |Gx| + |Gy|, unsigned, `DATA_W+3` bits. It cannot overflow because its maximum is 8·(2^DATA_W−1).

**Output**
- Binary mode (mode=0): `data_out` = EDGE_VAL if mag ≥ threshold, else FLAT_VAL.
- Magnitude mode (mode=1): `data_out` = min(mag, 2^DATA_W−1).

**Frame structure and control latching**
- Only interior pixels are output: (IMG_W−2)·(IMG_H−2) outputs per frame, in raster order. Border pixels produce no output.
- `threshold` and `mode` are latched when pixel (0,0) is accepted and held for the whole frame. Changes mid-frame take effect at the next frame.
- The registers power up with threshold = 12 and mode = 0 until the first frame starts.

## Timing

**Latency**
- `in_valid` sampled at edge t with a window-valid pixel gives `out_valid` = 1 in the cycle after edge t+3. Latency is 3 cycles and fixed.
- Pipeline stages:
  - t: window update.
  - t+1: Gx/Gy register.
  - t+2: mag register.
  - t+3: `data_out`, `out_valid`, `frame_done` register.

**Bubbles**
- Gaps in `in_valid` propagate as `out_valid` = 0.
- The pipeline never stalls or drops a pixel, and continuous `in_valid` gives continuous output.

**Frame boundaries**
- Frames may be back-to-back with no gap.
- Line IMG_H−1 of frame N and line 0 of frame N+1 are never combined, because row-based gating blocks those windows.

**`frame_done`**
- Asserted together with `out_valid` for the pixel with centre (IMG_H−2, IMG_W−2).

**Reset**
- Values while `sys_rst` is high: `data_out` = 0, `out_valid` = 0, `frame_done` = 0, counters 0, window 0, pipeline valid bits 0.
- A mid-frame reset abandons the frame.
- The first `in_valid` after reset is treated as pixel (0,0).

## Test plan

- **Flat frame.** DATA_W=8, IMG_W=8, IMG_H=6, all pixels 50, threshold 12, mode 0, continuous `in_valid` → 24 outputs, all 255. `frame_done` accompanies the 24th output, and the first output appears 3 cycles after pixel (2,2).
- **Vertical step.** Columns 0–3 = 0, columns 4–7 = 100, mode 0 → each output row (centre cols 1..6) is 255,255,0,0,255,255. Per row, centre cols 3 and 4 have mag = 400 and all others 0.
- **Magnitude mode.** Same step image, mode 1 → each output row is 0,0,255,255,0,0, saturated from 400. A horizontal step 0→10 gives mag 40 → `data_out` 40.
- **Gapped input.** Flat frame with `in_valid` deasserted for 1–5 random cycles between pixels → identical 24 outputs, each exactly 3 cycles after its completing pixel, and no extra outputs.
- **Mid-frame changes.** Change `threshold` to 500 mid-frame → the current frame is unchanged, and the next step-edge frame is all 255. Assert `sys_rst` during row 3 → outputs clear immediately, and a following complete frame gives exactly 24 correct outputs.
- **Back-to-back frames.** Three back-to-back frames (flat, step, flat) → 72 outputs, with no cross-frame contamination at the row boundaries and three `frame_done` pulses.

Source files
------------

// File: rtl/sobel_edge_param.sv
// Streaming Sobel edge detector: two inferred line buffers feed a 3x3 window,
// followed by a three-stage |Gx|+|Gy| pipeline with binary or magnitude output.
module sobel_edge_param #(
  parameter int                DATA_W   = 8,
  parameter int                IMG_W    = 180,
  parameter int                IMG_H    = 180,
  parameter logic [DATA_W-1:0] EDGE_VAL = '0,
  parameter logic [DATA_W-1:0] FLAT_VAL = '1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  input  logic [DATA_W+2:0] threshold,
  input  logic              mode,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              frame_done
);

  localparam int SW = DATA_W + 3;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [SW-1:0] THR_INIT = SW'(12);

  function automatic logic signed [SW-1:0] ext(input logic [DATA_W-1:0] px);
    return $signed({3'b000, px});
  endfunction

  function automatic logic [SW-1:0] abs_val(input logic signed [SW-1:0] v);
    return v[SW-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [DATA_W-1:0] sat_pix(input logic [SW-1:0] m);
    return (|m[SW-1:DATA_W]) ? {DATA_W{1'b1}} : m[DATA_W-1:0];
  endfunction

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [SW-1:0]     thr_q, thr_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] ram0 [IMG_W];
  logic [DATA_W-1:0] ram1 [IMG_W];
  logic [DATA_W-1:0] top_px, mid_px;
  logic [DATA_W-1:0] win_q [3][3];
  logic [DATA_W-1:0] win_d [3][3];
  logic              vld_p0_q, vld_p0_d, last_p0_q, last_p0_d;

  logic signed [SW-1:0] a1, a2, a3, b1, b3, c1, c2, c3;
  logic signed [SW-1:0] gx_p1_q, gx_p1_d, gy_p1_q, gy_p1_d;
  logic [SW-1:0]        thr_p1_q, thr_p1_d;
  logic                 mode_p1_q, mode_p1_d, vld_p1_q, vld_p1_d, last_p1_q, last_p1_d;

  logic [SW-1:0]        mag_p2_q, mag_p2_d, thr_p2_q, thr_p2_d;
  logic                 mode_p2_q, mode_p2_d, vld_p2_q, vld_p2_d, last_p2_q, last_p2_d;

  logic [DATA_W-1:0]    data_out_q, data_out_d;
  logic                 out_valid_q, out_valid_d, frame_done_q, frame_done_d;

  assign top_px = ram1[col_q];
  assign mid_px = ram0[col_q];

  // Stage p0: raster counters, per-frame control latch, line buffers, window
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    thr_d  = thr_q;
    mode_d = mode_q;
    if (in_valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (col_q == '0 && row_q == '0) begin
        thr_d  = threshold;
        mode_d = mode;
      end
    end
  end

  always_comb begin
    win_d = win_q;
    if (in_valid) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = top_px;
      win_d[1][2] = mid_px;
      win_d[2][2] = data_in;
    end
    // Row gating keeps windows from straddling two frames.
    vld_p0_d  = in_valid && (row_q >= RW'(2)) && (col_q >= CW'(2));
    last_p0_d = in_valid && (row_q == ROW_LAST) && (col_q == COL_LAST);
  end

  always_ff @(posedge sys_clk) begin
    if (in_valid) begin
      ram1[col_q] <= mid_px;
      ram0[col_q] <= data_in;
    end
  end

  // Stage p1: gradients
  always_comb begin
    a1 = ext(win_q[0][0]);
    a2 = ext(win_q[0][1]);
    a3 = ext(win_q[0][2]);
    b1 = ext(win_q[1][0]);
    b3 = ext(win_q[1][2]);
    c1 = ext(win_q[2][0]);
    c2 = ext(win_q[2][1]);
    c3 = ext(win_q[2][2]);
    gx_p1_d   = (a3 - a1) + ((b3 - b1) <<< 1) + (c3 - c1);
    gy_p1_d   = (a1 - c1) + ((a2 - c2) <<< 1) + (a3 - c3);
    // thr_q/mode_q only change on pixel (0,0), which is never a window pixel,
    // so sampling them here pins the current frame's settings to this pixel.
    thr_p1_d  = thr_q;
    mode_p1_d = mode_q;
    vld_p1_d  = vld_p0_q;
    last_p1_d = last_p0_q;
  end

  // Stage p2: magnitude
  always_comb begin
    mag_p2_d  = abs_val(gx_p1_q) + abs_val(gy_p1_q);
    thr_p2_d  = thr_p1_q;
    mode_p2_d = mode_p1_q;
    vld_p2_d  = vld_p1_q;
    last_p2_d = last_p1_q;
  end

  // Stage p3: output selection
  always_comb begin
    data_out_d = data_out_q;
    if (vld_p2_q) begin
      if (mode_p2_q) data_out_d = sat_pix(mag_p2_q);
      else           data_out_d = (mag_p2_q >= thr_p2_q) ? EDGE_VAL : FLAT_VAL;
    end
    out_valid_d  = vld_p2_q;
    frame_done_d = vld_p2_q && last_p2_q;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      col_q        <= '0;
      row_q        <= '0;
      thr_q        <= THR_INIT;
      mode_q       <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
      vld_p0_q     <= 1'b0;
      last_p0_q    <= 1'b0;
      vld_p1_q     <= 1'b0;
      last_p1_q    <= 1'b0;
      vld_p2_q     <= 1'b0;
      last_p2_q    <= 1'b0;
      data_out_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      thr_q        <= thr_d;
      mode_q       <= mode_d;
      win_q        <= win_d;
      vld_p0_q     <= vld_p0_d;
      last_p0_q    <= last_p0_d;
      vld_p1_q     <= vld_p1_d;
      last_p1_q    <= last_p1_d;
      vld_p2_q     <= vld_p2_d;
      last_p2_q    <= last_p2_d;
      data_out_q   <= data_out_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    gx_p1_q   <= gx_p1_d;
    gy_p1_q   <= gy_p1_d;
    thr_p1_q  <= thr_p1_d;
    mode_p1_q <= mode_p1_d;
    mag_p2_q  <= mag_p2_d;
    thr_p2_q  <= thr_p2_d;
    mode_p2_q <= mode_p2_d;
  end

  assign data_out   = data_out_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;

endmodule
